// File: rtl/sym_ram_tdp_be.sv
`default_nettype none
// ============================================================================
//  Module   : sym_ram_tdp_be
//  Brief    : Single-clock true dual-port RAM with per-byte write enables,
//             selectable same-port read-during-write mode, configurable
//             output pipeline with per-port valid strobes, deterministic
//             write-write collision priority and a registered collision flag.
//  Revision : 1.0 - initial release
// ============================================================================
module sym_ram_tdp_be #(
   parameter int WIDTH       = 32,
   parameter int BYTE_WIDTH  = 8,
   parameter int SIZE        = 1024,
   parameter int ADDRWIDTH   = 10,
   parameter int N_REGISTERS = 1,
   parameter int WRITE_MODE  = 0,
   parameter int PRIORITY_A  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enaA,
   input  logic [WIDTH/BYTE_WIDTH-1:0]      weA,
   input  logic [ADDRWIDTH-1:0]             addrA,
   input  logic [WIDTH-1:0]                 diA,
   output logic [WIDTH-1:0]                 doA,
   output logic                             vldA,
   input  logic                             enaB,
   input  logic [WIDTH/BYTE_WIDTH-1:0]      weB,
   input  logic [ADDRWIDTH-1:0]             addrB,
   input  logic [WIDTH-1:0]                 diB,
   output logic [WIDTH-1:0]                 doB,
   output logic                             vldB,
   output logic                             collision
);

   localparam int NBYTES = WIDTH / BYTE_WIDTH;
   // Core read register plus the extra output stages.
   localparam int LAT    = N_REGISTERS + 1;
   // Index width actually needed to address SIZE words.
   localparam int MEM_AW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [ADDRWIDTH:0] C_SIZE = (ADDRWIDTH + 1)'(SIZE);

   // Ports gathered into two-entry packed arrays (index 0 = A, 1 = B) so
   // the read path is described once for both ports.
   logic [1:0]                w_ena;
   logic [1:0][NBYTES-1:0]    w_we;
   logic [1:0][ADDRWIDTH-1:0] w_addr;
   logic [1:0][WIDTH-1:0]     w_di;
   logic [1:0][WIDTH-1:0]     w_old;
   logic [1:0][NBYTES-1:0]    w_wr;
   logic [1:0][MEM_AW-1:0]    w_idx;
   logic [1:0]                w_inrange;
   logic [1:0][WIDTH-1:0]     w_do;
   logic [1:0]                w_vld;
   logic                      w_same_addr;
   logic [NBYTES-1:0]         w_overlap;
   logic                      collision_d;
   logic                      collision_q;

   assign w_ena  = {enaB, enaA};
   assign w_we   = {weB, weA};
   assign w_addr = {addrB, addrA};
   assign w_di   = {diB, diA};

   // Address decode: storage index and in-range qualification per port.
   always_comb begin
      w_inrange = '0;
      w_idx     = '0;
      for (int p = 0; p < 2; p++) begin
         w_inrange[p] = ({1'b0, w_addr[p]} < C_SIZE);
         w_idx[p]     = w_addr[p][MEM_AW-1:0];
      end
   end

   // Effective byte-lane writes: drop out-of-range and reset-time writes,
   // then hand every lane both ports hit at the same address to the winner
   // so the two write sets are always disjoint.
   always_comb begin
      w_same_addr = (addrA == addrB);
      w_wr        = '0;
      for (int p = 0; p < 2; p++) begin
         w_wr[p] = (w_ena[p] && w_inrange[p] && !rst) ? w_we[p] : '0;
      end
      w_overlap = w_same_addr ? (w_wr[0] & w_wr[1]) : '0;
      if (PRIORITY_A != 0) begin
         w_wr[1] = w_wr[1] & ~w_overlap;
      end else begin
         w_wr[0] = w_wr[0] & ~w_overlap;
      end
   end

   // Storage is split into one array per byte lane; each lane sees at most
   // one writer per address per cycle, so no ordering between ports matters.
   for (genvar k = 0; k < NBYTES; k++) begin : g_lane
      logic [BYTE_WIDTH-1:0] mem_lane [SIZE];

      // Lane write from both ports (contents are never reset).
      always_ff @(posedge clk) begin
         if (w_wr[0][k]) begin
            mem_lane[w_idx[0]] <= diA[k*BYTE_WIDTH +: BYTE_WIDTH];
         end
         if (w_wr[1][k]) begin
            mem_lane[w_idx[1]] <= diB[k*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end

      // Asynchronous lane read gives the pre-write word to both ports.
      assign w_old[0][k*BYTE_WIDTH +: BYTE_WIDTH] = mem_lane[w_idx[0]];
      assign w_old[1][k*BYTE_WIDTH +: BYTE_WIDTH] = mem_lane[w_idx[1]];
   end

   // Per-port read path: stage 0 is the core read register, the remaining
   // stages are a plain shift chain carrying data and valid in lockstep.
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [WIDTH-1:0] data_d [LAT];
      logic [WIDTH-1:0] data_q [LAT];
      logic [LAT-1:0]   vld_d;
      logic [LAT-1:0]   vld_q;
      logic [WIDTH-1:0] w_merged;
      logic             w_launch;

      // Next-state of the read chain; NO_CHANGE writes leave the core
      // register untouched and launch no valid.
      always_comb begin
         w_merged = w_old[p];
         for (int k = 0; k < NBYTES; k++) begin
            if (w_we[p][k]) begin
               w_merged[k*BYTE_WIDTH +: BYTE_WIDTH] = w_di[p][k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
         w_launch  = w_ena[p] && ((WRITE_MODE != 2) || (w_we[p] == '0));
         vld_d     = '0;
         data_d[0] = data_q[0];
         if (w_launch) begin
            data_d[0] = (WRITE_MODE == 1) ? w_merged : w_old[p];
         end
         vld_d[0] = w_launch;
         for (int i = 1; i < LAT; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end

      // Read chain registers; reset clears data and discards in-flight valids.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q <= '{default: '0};
            vld_q  <= '0;
         end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
         end
      end

      assign w_do[p]  = data_q[LAT-1];
      assign w_vld[p] = vld_q[LAT-1];
   end

   assign doA  = w_do[0];
   assign vldA = w_vld[0];
   assign doB  = w_do[1];
   assign vldB = w_vld[1];

   // Collision condition: both ports active on one address with any write.
   always_comb begin
      collision_d = enaA && enaB && w_same_addr && ((|weA) || (|weB));
   end

   // Registered one-cycle collision pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         collision_q <= 1'b0;
      end else begin
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;

endmodule
`default_nettype wire
